prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
- Single-clock, runtime-programmable successor to the fixed ripple divide-by-64 chain in the decimation filter.
- One synchronous counter replaces the cascaded toggle stages. It produces a near-50% divided clock level plus a one-cycle decimation strobe (clock-enable) per output period.
- Ratio is reprogrammable between decimation stages. A new ratio takes effect only at a period boundary, so the CIC/decimator downstream never sees a runt period.

Parameters:
- CNT_W, 8, width of ratio and counter; legal ratios MIN_DIV..2^CNT_W-1.
- DEFAULT_DIV, 64, ratio loaded at reset.
- MIN_DIV, 2, smallest accepted ratio; must be >= 2.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; low freezes all state.
- div_ratio  in  CNT_W  requested ratio N, sampled when div_load=1.
- div_load  in  1  single-cycle load request.
- load_err  out  1  one-cycle pulse, 1 cycle after a rejected load.
- clk_out  out  1  divided clock level, registered.
- strobe  out  1  one-cycle pulse on the last count of each period, registered.
- cnt_out  out  CNT_W  current phase count, 0..N-1.
- div_cur  out  CNT_W  ratio currently in force.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cnt=0, div_cur=DEFAULT_DIV, pending_valid=0.
  - clk_out=0, strobe=0, load_err=0.
  - rst overrides en, div_load and sync.
- Counting (en=1): cnt increments by 1 per clk. When cnt==div_cur-1, the next cnt is 0 ("wrap").
- en=0:
  - cnt, clk_out and div_cur hold; strobe=0.
  - div_load is still accepted into pending.
- strobe: registered, so it is high in the cycle where cnt==div_cur-1 and en=1. It is asserted exactly once per N enabled cycles.
- clk_out: a flop whose value always equals (cnt >= div_cur - floor(div_cur/2)). It is computed from the next-state count, so the output is glitch-free.
  - N=64: 32 low, 32 high.
  - N=5: 3 low, 2 high.
- Ratio load:
  - div_load=1 with MIN_DIV <= div_ratio <= 2^CNT_W-1: value goes to pending and pending_valid is set.
  - Otherwise the load is rejected: load_err pulses the next cycle and pending is unchanged.
- Apply: on a wrap edge with pending_valid=1, div_cur <= pending, pending_valid <= 0, cnt <= 0.
- Simultaneous events:
  - Valid load on a wrap edge: the new value bypasses pending and takes effect at that wrap.
  - Two loads before a wrap: the last one wins.
- Reset mid-period: the period is abandoned and the pending ratio is discarded. No strobe is generated for the partial period.
- Steady state: latency from a valid div_load to the first period at the new ratio is at most old N cycles.

Optional Feature:
- Macro: PROG_CLK_DIVIDER_SYNC_EN.
- Defined: adds input port sync (1 bit). sync=1 at an edge (no rst) forces:
  - cnt<=0 and clk_out<=0;
  - pending applied immediately if valid;
  - strobe=0 that cycle.
  - sync overrides en; rst overrides sync.
  - Used to phase-align multiple channel dividers.
- Undefined: no sync port. Realignment only via rst.

Decomposition:
- Package decim_pkg:
  - constants CNT_W, DEFAULT_DIV, MIN_DIV;
  - typedef div_ratio_t = logic [CNT_W-1:0];
  - function div_ratio_valid().
- One sub-module, div_ratio_ctrl: load validation, pending register, load_err, and apply-at-wrap logic. Output is div_cur.
- The counter, clk_out and strobe stay in the top module.

Test Plan:
- Reset then en=1 for 256 cycles:
  - strobe exactly at cycles 63, 127, 191, 255;
  - clk_out 32 low / 32 high;
  - div_cur=64.
- Load div_ratio=5 at cnt=10:
  - remainder of the 64-period completes;
  - then strobe every 5 cycles;
  - clk_out pattern 0,0,0,1,1.
- Load div_ratio=1, then 0:
  - load_err pulses one cycle after each;
  - div_cur stays 64;
  - period unchanged.
- Load 8 exactly on a wrap cycle: next period is 8 cycles. Load 8 then 12 within one period: only 12 applies.
- en toggled low for 7 cycles mid-period: cnt/clk_out hold and strobe is absent. Strobe spacing counts only enabled cycles.
- rst asserted at cnt=40 with pending=16: cnt=0, div_cur=64, pending dropped, first strobe 64 enabled cycles later. With SYNC_EN, sync at cnt=20 gives the same restart but keeps div_cur.

Source files
------------

// File: rtl/decim_pkg.sv
// Shared constants, ratio type and ratio helpers for the programmable decimation clock divider.
// Widths here fix the ratio register, the phase counter and the interface buses.
package decim_pkg;

   localparam int CNT_W       = 8;
   localparam int DEFAULT_DIV = 64;
   localparam int MIN_DIV     = 2;

   typedef logic [CNT_W-1:0] div_ratio_t;

   localparam div_ratio_t DIV_ONE = div_ratio_t'(1);

   // The upper bound 2^CNT_W-1 is implied by the width of div_ratio_t.
   function automatic logic div_ratio_valid(input div_ratio_t r);
      return int'(r) >= MIN_DIV;
   endfunction

   // First phase count at which the divided clock is high: N - floor(N/2).
   function automatic div_ratio_t hi_thresh(input div_ratio_t n);
      return n - (n >> 1);
   endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control and status bundle for prog_clk_divider; the master drives ratio/enable, the slave is the divider.
// The sync request exists only when PROG_CLK_DIVIDER_SYNC_EN is defined.
interface prog_clk_divider_if;
   import decim_pkg::*;

   logic       en;
   div_ratio_t div_ratio;
   logic       div_load;
`ifdef PROG_CLK_DIVIDER_SYNC_EN
   logic       sync;
`endif
   logic       load_err;
   logic       clk_out;
   logic       strobe;
   div_ratio_t cnt_out;
   div_ratio_t div_cur;

   modport master (
      output en, div_ratio, div_load,
`ifdef PROG_CLK_DIVIDER_SYNC_EN
      output sync,
`endif
      input  load_err, clk_out, strobe, cnt_out, div_cur
   );

   modport slave (
      input  en, div_ratio, div_load,
`ifdef PROG_CLK_DIVIDER_SYNC_EN
      input  sync,
`endif
      output load_err, clk_out, strobe, cnt_out, div_cur
   );

endinterface

// File: rtl/div_ratio_ctrl.sv
// Ratio load validation, pending register and apply-at-boundary logic; load_err is registered (1 cycle).
// Loads are accepted every cycle regardless of count enable; no backpressure.
module div_ratio_ctrl
   import decim_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       div_load,
   input  div_ratio_t div_ratio,
   input  logic       apply,
   output logic       load_err,
   output div_ratio_t div_cur,
   output div_ratio_t div_nxt
);

   logic       load_ok;
   logic       load_err_d, load_err_q;
   logic       pend_vld_d, pend_vld_q;
   div_ratio_t pend_d, pend_q;
   div_ratio_t div_cur_d, div_cur_q;

   always_comb begin
      load_ok    = div_load && div_ratio_valid(div_ratio);
      load_err_d = div_load && !load_ok;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      div_cur_d  = div_cur_q;
      // A valid load coinciding with a period boundary skips the pending stage.
      if (apply) begin
         if (load_ok) begin
            div_cur_d = div_ratio;
         end else if (pend_vld_q) begin
            div_cur_d = pend_q;
         end
         pend_vld_d = 1'b0;
      end else if (load_ok) begin
         pend_d     = div_ratio;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_err_q <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_q     <= '0;
         div_cur_q  <= div_ratio_t'(DEFAULT_DIV);
      end else begin
         load_err_q <= load_err_d;
         pend_vld_q <= pend_vld_d;
         pend_q     <= pend_d;
         div_cur_q  <= div_cur_d;
      end
   end

   assign load_err = load_err_q;
   assign div_cur  = div_cur_q;
   assign div_nxt  = div_cur_d;

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider: registered divided clock, one-cycle strobe per period, ratio swaps only at wrap.
// All outputs registered; en=0 freezes phase. Optional sync port under PROG_CLK_DIVIDER_SYNC_EN.
module prog_clk_divider
   import decim_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   prog_clk_divider_if.slave   bus
);

   logic       sync_req;
   logic       wrap;
   logic       apply;
   div_ratio_t div_cur;
   div_ratio_t div_nxt;
   div_ratio_t cnt_d, cnt_q;
   logic       clk_out_d, clk_out_q;
   logic       strobe_d, strobe_q;

`ifdef PROG_CLK_DIVIDER_SYNC_EN
   assign sync_req = bus.sync;
`else
   assign sync_req = 1'b0;
`endif

   assign wrap  = bus.en && (cnt_q == div_cur - DIV_ONE);
   assign apply = wrap || sync_req;

   div_ratio_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .div_load  (bus.div_load),
      .div_ratio (bus.div_ratio),
      .apply     (apply),
      .load_err  (bus.load_err),
      .div_cur   (div_cur),
      .div_nxt   (div_nxt)
   );

   // Outputs derive from next-state count and ratio so they line up with cnt_q after the edge.
   always_comb begin
      cnt_d = cnt_q;
      if (apply) begin
         cnt_d = '0;
      end else if (bus.en) begin
         cnt_d = cnt_q + DIV_ONE;
      end
      clk_out_d = (cnt_d >= hi_thresh(div_nxt));
      strobe_d  = bus.en && !sync_req && (cnt_d == div_nxt - DIV_ONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         strobe_q  <= strobe_d;
      end
   end

   assign bus.cnt_out = cnt_q;
   assign bus.clk_out = clk_out_q;
   assign bus.strobe  = strobe_q;
   assign bus.div_cur = div_cur;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed plus randomized bench for prog_clk_divider against a cycle-level integer reference model.
`timescale 1ns/1ps
module tb_prog_clk_divider;
   import decim_pkg::*;

`ifdef PROG_CLK_DIVIDER_SYNC_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prog_clk_divider_if dif ();

   prog_clk_divider dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   int n_asrt = 0;
   int n_fail = 0;

   // reference model state
   int m_cnt, m_n, m_pend;
   bit m_pv, m_stb, m_err, m_clk;

   int gcyc;
   int stb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_asrt++;
      assert (obs === 32'(exp)) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_stb(input string tag, input int idx, input int exp);
      int obs;
      obs = (idx < stb_q.size()) ? stb_q[idx] : -1;
      chk(tag, obs, exp);
   endtask

   task automatic model_edge(input bit e, input bit ld, input int r, input bit rs, input bit sy);
      bit ok, sw, wrap;
      if (rs) begin
         m_cnt = 0; m_n = DEFAULT_DIV; m_pv = 0;
         m_err = 0; m_stb = 0; m_clk = 0;
         return;
      end
      ok    = ld && (r >= MIN_DIV) && (r < (1 << CNT_W));
      m_err = ld && !ok;
      sw    = SYNC_ON && sy;
      wrap  = e && (m_cnt == m_n - 1);
      if (sw || wrap) begin
         m_cnt = 0;
         if (ok) m_n = r;
         else if (m_pv) m_n = m_pend;
         m_pv = 0;
      end else begin
         if (e) m_cnt = m_cnt + 1;
         if (ok) begin
            m_pend = r;
            m_pv   = 1;
         end
      end
      m_stb = e && !sw && (m_cnt == m_n - 1);
      m_clk = (m_cnt >= m_n - m_n / 2);
   endtask

   task automatic step(input bit e, input bit ld, input int r, input bit rs, input bit sy);
      dif.en        = e;
      dif.div_load  = ld;
      dif.div_ratio = r[CNT_W-1:0];
      rst           = rs;
`ifdef PROG_CLK_DIVIDER_SYNC_EN
      dif.sync      = sy;
`endif
      @(posedge clk);
      model_edge(e, ld, r, rs, sy);
      #1;
      gcyc++;
      if (dif.strobe === 1'b1) stb_q.push_back(gcyc);
      chk("cnt_out", dif.cnt_out, m_cnt);
      chk("div_cur", dif.div_cur, m_n);
      chk("clk_out", dif.clk_out, m_clk);
      chk("strobe", dif.strobe, m_stb);
      chk("load_err", dif.load_err, m_err);
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic adv_to(input int target);
      for (int i = 0; i < 600 && int'(dif.cnt_out) != target; i++) step(1, 0, 0, 0, 0);
      chk("adv_to", dif.cnt_out, target);
   endtask

   task automatic restart_log();
      gcyc = 0;
      stb_q.delete();
   endtask

   initial begin
      int hi;
      bit e, ld, rs, sy;
      int r;

      rst = 1'b1; dif.en = 1'b0; dif.div_load = 1'b0; dif.div_ratio = '0;
`ifdef PROG_CLK_DIVIDER_SYNC_EN
      dif.sync = 1'b0;
`endif
      gcyc = 0; m_pend = 0;

      // reset and the default 64 ratio
      step(0, 0, 0, 1, 0);
      chk("rst_cnt", dif.cnt_out, 0);
      chk("rst_div", dif.div_cur, 64);
      chk("rst_clk", dif.clk_out, 0);
      restart_log();
      hi = 0;
      for (int i = 0; i < 64; i++) begin
         hi += int'(dif.clk_out);
         step(1, 0, 0, 0, 0);
      end
      run(192);
      chk("clk_hi_64", hi, 32);
      chk("stb_cnt_256", stb_q.size(), 4);
      chk_stb("stb0", 0, 63);
      chk_stb("stb1", 1, 127);
      chk_stb("stb2", 2, 191);
      chk_stb("stb3", 3, 255);

      // rejected loads
      step(1, 1, 1, 0, 0);
      chk("err_after_1", dif.load_err, 1);
      step(1, 1, 0, 0, 0);
      chk("err_after_0", dif.load_err, 1);
      step(1, 0, 0, 0, 0);
      chk("err_clear", dif.load_err, 0);
      adv_to(63);
      restart_log();
      run(64);
      chk_stb("rej_period", 0, 64);
      chk("rej_div", dif.div_cur, 64);

      // load 5 mid-period
      adv_to(10);
      restart_log();
      step(1, 1, 5, 0, 0);
      run(64);
      chk_stb("n5_first", 0, 53);
      chk_stb("n5_second", 1, 58);
      chk_stb("n5_third", 2, 63);
      chk("n5_div", dif.div_cur, 5);

      // load 8 on a wrap edge
      adv_to(4);
      restart_log();
      step(1, 1, 8, 0, 0);
      chk("wrap8_div", dif.div_cur, 8);
      chk("wrap8_cnt", dif.cnt_out, 0);
      run(16);
      chk_stb("n8_first", 0, 8);
      chk_stb("n8_second", 1, 16);

      // two loads in one period: last one wins
      step(1, 1, 8, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 12, 0, 0);
      run(5);
      chk("last_wins_div", dif.div_cur, 12);
      chk("last_wins_cnt", dif.cnt_out, 0);

      // en low for 7 cycles mid-period
      adv_to(4);
      restart_log();
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
      chk("hold_cnt", dif.cnt_out, 4);
      chk("hold_nostb", stb_q.size(), 0);
      run(20);
      chk_stb("en_gap_first", 0, 14);
      chk_stb("en_gap_second", 1, 26);

      // reset mid-period drops the pending ratio
      step(1, 1, 64, 0, 0);
      run(11);
      chk("back64_div", dif.div_cur, 64);
      adv_to(30);
      step(1, 1, 16, 0, 0);
      adv_to(40);
      step(1, 0, 0, 1, 0);
      chk("midrst_cnt", dif.cnt_out, 0);
      chk("midrst_div", dif.div_cur, 64);
      restart_log();
      run(64);
      chk("midrst_nstb", stb_q.size(), 1);
      chk_stb("midrst_stb", 0, 63);
      chk("midrst_drop", dif.div_cur, 64);

`ifdef PROG_CLK_DIVIDER_SYNC_EN
      adv_to(20);
      step(1, 0, 0, 0, 1);
      chk("sync_cnt", dif.cnt_out, 0);
      chk("sync_div", dif.div_cur, 64);
      chk("sync_clk", dif.clk_out, 0);
      adv_to(10);
      step(1, 1, 16, 0, 0);
      adv_to(20);
      step(1, 0, 0, 0, 1);
      chk("sync_apply_div", dif.div_cur, 16);
      chk("sync_apply_cnt", dif.cnt_out, 0);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         e  = ($urandom_range(0, 9) != 0);
         ld = ($urandom_range(0, 15) == 0);
         r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
         rs = ($urandom_range(0, 499) == 0);
         sy = ($urandom_range(0, 199) == 0);
         step(e, ld, r, rs, sy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
